// File: rtl/hs_to_stream_adapter_pkg.sv
// Shared types and helpers for the ap_hs <-> AXI4-Stream adapters.
package hs_stream_pkg;

    localparam int STREAM_DATA_W = 64;
    localparam int PKT_CNT_W     = 16;

    typedef logic [STREAM_DATA_W-1:0] stream_data_t;

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/hs_to_stream_adapter_if.sv
// ap_hs input side and AXI4-Stream output side of the adapter, bundled.
interface hs_to_stream_adapter_if;
    import hs_stream_pkg::*;

    stream_data_t in_hs;
    logic         in_hs_ap_vld;
    logic         in_hs_ap_ack;
    stream_data_t outStream_tdata;
    logic         outStream_tvalid;
    logic         outStream_tready;
    logic         outStream_tlast;

    // The adapter is the stream master; the accelerator/downstream pair is the slave view.
    modport master (
        input  in_hs, in_hs_ap_vld, outStream_tready,
        output in_hs_ap_ack, outStream_tdata, outStream_tvalid, outStream_tlast
    );

    modport slave (
        output in_hs, in_hs_ap_vld, outStream_tready,
        input  in_hs_ap_ack, outStream_tdata, outStream_tvalid, outStream_tlast
    );

endinterface

// File: rtl/hs_to_stream_adapter_fifo.sv
// First-word-fall-through FIFO: head word is always visible on o_pop_data.
module sync_fifo_fwft
    import hs_stream_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = STREAM_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_pop_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [ptr_width(DEPTH):0]    o_count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_comb begin
        // NOTE: default first so every path assigns w_count_next and no latch is inferred.
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
        end
    end

    // NOTE: storage is not reset; count gates visibility, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;

endmodule

// File: rtl/hs_to_stream_adapter.sv
// HLS ap_hs output -> 64-bit AXI4-Stream master with FIFO decoupling and fixed-size TLAST.
module hs_to_stream_adapter
    import hs_stream_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int PKT_WORDS = 1
) (
    input  logic                     clk,
    input  logic                     aresetn,
    hs_to_stream_adapter_if.master   hs,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int                   CNT_W    = ptr_width(DEPTH) + 1;
    localparam logic [PKT_CNT_W-1:0] PKT_LAST = PKT_CNT_W'(PKT_WORDS - 1);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("hs_to_stream_adapter: DEPTH must be a power of two and >= 2");
    end
    if (PKT_WORDS < 1 || PKT_WORDS > 65535) begin : g_bad_pkt
        $error("hs_to_stream_adapter: PKT_WORDS must be in 1..65535");
    end

    logic [1:0]           r_rst_sync;
    logic [PKT_CNT_W-1:0] r_pkt_cnt;
    logic                 w_in_reset;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_ack;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_pkt_last;
    logic [CNT_W-1:0]     w_count;

    // Assert asynchronously, release two clocks after aresetn rises.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) r_rst_sync <= '0;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_in_reset = !r_rst_sync[1];
    assign w_ack      = !w_full && !w_in_reset;
    assign w_push     = hs.in_hs_ap_vld && w_ack;
    assign w_pop      = !w_empty && hs.outStream_tready;
    assign w_pkt_last = (r_pkt_cnt == PKT_LAST);

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (STREAM_DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (aresetn),
        .i_push      (w_push),
        .i_push_data (hs.in_hs),
        .i_pop       (w_pop),
        .o_pop_data  (hs.outStream_tdata),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)   r_pkt_cnt <= '0;
        else if (w_pop) r_pkt_cnt <= w_pkt_last ? '0 : r_pkt_cnt + PKT_CNT_W'(1);
    end

    assign hs.in_hs_ap_ack     = w_ack;
    assign hs.outStream_tvalid = !w_empty;
    assign hs.outStream_tlast  = !w_empty && w_pkt_last;
    assign occupancy           = w_count;

endmodule

// File: tb/tb_hs_to_stream_adapter.sv
// Directed bench: DEPTH=2/PKT_WORDS=4 for handshake cases, DEPTH=4/PKT_WORDS=3 for wrap traffic.
module tb_hs_to_stream_adapter;
    import hs_stream_pkg::*;

    logic       clk = 1'b0;
    logic       aresetn;
    logic [1:0] occ0;
    logic [2:0] occ1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hs_to_stream_adapter_if if0 ();
    hs_to_stream_adapter_if if1 ();

    hs_to_stream_adapter #(.DEPTH(2), .PKT_WORDS(4)) dut0 (
        .clk       (clk),
        .aresetn   (aresetn),
        .hs        (if0),
        .occupancy (occ0)
    );

    hs_to_stream_adapter #(.DEPTH(4), .PKT_WORDS(3)) dut1 (
        .clk       (clk),
        .aresetn   (aresetn),
        .hs        (if1),
        .occupancy (occ1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Release reset at a falling edge and wait (bounded) for dut0 to start acking.
    task automatic release_and_wait(input string tag);
        bit seen = 1'b0;
        aresetn = 1'b1;
        for (int i = 0; i < 3 && !seen; i++) begin
            tick();
            check({tag, "_no_word"}, 64'(if0.outStream_tvalid), 64'd0);
            seen = if0.in_hs_ap_ack;
        end
        check({tag, "_ack"}, 64'(if0.in_hs_ap_ack), 64'd1);
    endtask

    // Push n consecutive words into dut0 with tready=1; packet counter assumed at 0.
    task automatic stream_burst0(input string tag, input logic [63:0] base, input int n);
        if0.outStream_tready = 1'b1;
        for (int i = 0; i <= n + 1; i++) begin
            if (i >= 1 && i <= n) begin
                check({tag, "_tvalid"}, 64'(if0.outStream_tvalid), 64'd1);
                check({tag, "_tdata"}, if0.outStream_tdata, base + 64'(i - 1));
                check({tag, "_tlast"}, 64'(if0.outStream_tlast), 64'(((i - 1) % 4) == 3));
            end else begin
                check({tag, "_idle"}, 64'(if0.outStream_tvalid), 64'd0);
            end
            if (i < n) check({tag, "_ack"}, 64'(if0.in_hs_ap_ack), 64'd1);
            if0.in_hs_ap_vld = (i < n);
            if0.in_hs        = base + 64'(i);
            tick();
        end
    endtask

    initial begin
        logic [63:0] q[$];
        logic [63:0] d;
        int          pushed;
        int          popped;
        int          cycles;
        bit          do_push;
        bit          do_pop;

        aresetn              = 1'b0;
        if0.in_hs            = 64'h55;
        if0.in_hs_ap_vld     = 1'b1;
        if0.outStream_tready = 1'b1;
        if1.in_hs            = '0;
        if1.in_hs_ap_vld     = 1'b0;
        if1.outStream_tready = 1'b0;

        // Reset held with valid data offered.
        repeat (3) tick();
        check("rst_ack",    64'(if0.in_hs_ap_ack),     64'd0);
        check("rst_tvalid", 64'(if0.outStream_tvalid), 64'd0);
        check("rst_tlast",  64'(if0.outStream_tlast),  64'd0);
        check("rst_occ",    64'(occ0),                 64'd0);
        check("rst_occ1",   64'(occ1),                 64'd0);
        check("rst_ack1",   64'(if1.in_hs_ap_ack),     64'd0);

        release_and_wait("rst_rel");
        if0.in_hs_ap_vld = 1'b0;
        tick();
        check("rst_spurious_tvalid", 64'(if0.outStream_tvalid), 64'd0);
        check("rst_spurious_occ",    64'(occ0),                 64'd0);

        // Back-to-back streaming, tlast on 0x13 and 0x17.
        stream_burst0("strm", 64'h10, 8);

        // Backpressure fills the 2-deep FIFO.
        if0.outStream_tready = 1'b0;
        if0.in_hs_ap_vld     = 1'b1;
        if0.in_hs            = 64'hA;
        tick();
        check("bp_ack1",   64'(if0.in_hs_ap_ack),     64'd1);
        check("bp_occ1",   64'(occ0),                 64'd1);
        check("bp_tvalid", 64'(if0.outStream_tvalid), 64'd1);
        check("bp_tdata1", if0.outStream_tdata,       64'hA);
        if0.in_hs = 64'hB;
        tick();
        check("bp_ack_full", 64'(if0.in_hs_ap_ack),    64'd0);
        check("bp_occ2",     64'(occ0),                64'd2);
        check("bp_hold",     if0.outStream_tdata,      64'hA);
        check("bp_tlast",    64'(if0.outStream_tlast), 64'd0);
        if0.in_hs = 64'hEE;
        tick();
        check("bp_hold2", if0.outStream_tdata, 64'hA);
        check("bp_occ2b", 64'(occ0),           64'd2);
        if0.outStream_tready = 1'b1;
        tick();
        if0.outStream_tready = 1'b0;
        if0.in_hs_ap_vld     = 1'b0;
        check("bp_pop_occ",   64'(occ0),             64'd1);
        check("bp_pop_ack",   64'(if0.in_hs_ap_ack), 64'd1);
        check("bp_pop_tdata", if0.outStream_tdata,   64'hB);

        // Simultaneous push and pop at count=1.
        if0.in_hs_ap_vld     = 1'b1;
        if0.in_hs            = 64'hC;
        if0.outStream_tready = 1'b1;
        tick();
        check("sim_occ",   64'(occ0),                64'd1);
        check("sim_tdata", if0.outStream_tdata,      64'hC);
        check("sim_tlast", 64'(if0.outStream_tlast), 64'd0);
        if0.in_hs = 64'hD;
        tick();
        check("sim_occ2",   64'(occ0),                64'd1);
        check("sim_tdata2", if0.outStream_tdata,      64'hD);
        check("sim_tlast2", 64'(if0.outStream_tlast), 64'd1);
        if0.in_hs_ap_vld = 1'b0;
        tick();
        check("sim_drain_tvalid", 64'(if0.outStream_tvalid), 64'd0);
        check("sim_drain_occ",    64'(occ0),                 64'd0);

        // Mid-packet reset: three words popped, fourth buffered.
        for (int k = 0; k < 4; k++) begin
            if0.in_hs_ap_vld = 1'b1;
            if0.in_hs        = 64'h20 + 64'(k);
            tick();
        end
        if0.in_hs_ap_vld     = 1'b0;
        if0.outStream_tready = 1'b0;
        check("mr_pre_tdata", if0.outStream_tdata,      64'h23);
        check("mr_pre_tlast", 64'(if0.outStream_tlast), 64'd1);
        aresetn = 1'b0;
        #1;
        check("mr_tvalid", 64'(if0.outStream_tvalid), 64'd0);
        check("mr_tlast",  64'(if0.outStream_tlast),  64'd0);
        check("mr_occ",    64'(occ0),                 64'd0);
        check("mr_ack",    64'(if0.in_hs_ap_ack),     64'd0);
        tick();
        release_and_wait("mr_rel");
        stream_burst0("mr_pkt", 64'h30, 4);

        // Random traffic through the 4-deep FIFO with 3-word packets.
        pushed = 0;
        popped = 0;
        cycles = 0;
        while (popped < 1000 && cycles < 20000) begin
            check("wrap_ack",    64'(if1.in_hs_ap_ack),     64'(q.size() < 4));
            check("wrap_tvalid", 64'(if1.outStream_tvalid), 64'(q.size() != 0));
            check("wrap_occ",    64'(occ1),                 64'(q.size()));
            d                    = {$urandom, $urandom};
            if1.in_hs            = d;
            if1.in_hs_ap_vld     = (pushed < 1000) && ($urandom_range(0, 9) < 7);
            if1.outStream_tready = ($urandom_range(0, 9) < 6);
            do_push = if1.in_hs_ap_vld && if1.in_hs_ap_ack;
            do_pop  = if1.outStream_tvalid && if1.outStream_tready && (q.size() != 0);
            if (do_pop) begin
                check("wrap_tdata", if1.outStream_tdata,      q[0]);
                check("wrap_tlast", 64'(if1.outStream_tlast), 64'((popped % 3) == 2));
                void'(q.pop_front());
                popped++;
            end
            if (do_push) begin
                q.push_back(d);
                pushed++;
            end
            tick();
            cycles++;
        end
        check("wrap_done", 64'(popped), 64'd1000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hs_to_stream_adapter.md
Name: hs_to_stream_adapter

Overview:
Converts an HLS ap_hs output port (data/vld/ack) into a 64-bit AXI4-Stream master. It is the opposite direction of the stream-to-handshake adapter and sits between an accelerator's ap_hs output and the hwruntime/interconnect stream input. A small FIFO decouples the accelerator from stream backpressure, and a word counter generates TLAST at fixed packet boundaries.

Parameters:
DEPTH, 2, FIFO depth in 64-bit words; power of two, >= 2.
PKT_WORDS, 1, words per stream packet; 1..65535; TLAST on the last word of each packet.

Ports:
clk  input  1  clock; all logic on rising edge
aresetn  input  1  asynchronous, active-low reset
in_hs  input  64  ap_hs data from accelerator
in_hs_ap_vld  input  1  accelerator presents valid data
in_hs_ap_ack  output  1  adapter accepts data this cycle
outStream_tdata  output  64  stream data
outStream_tvalid  output  1  stream data valid
outStream_tready  input  1  downstream ready
outStream_tlast  output  1  last word of packet
occupancy  output  $clog2(DEPTH)+1  words currently held in the FIFO

Behaviour:
- Reset is asynchronous and active-low: one clock (clk), reset aresetn. While aresetn=0: wr_ptr=0, rd_ptr=0, count=0, pkt_cnt=0, in_hs_ap_ack=0, outStream_tvalid=0, outStream_tlast=0, occupancy=0. Reset deassertion is synchronised internally (2-flop) before the FIFO accepts data.
- Reset mid-operation: all buffered words are discarded, and pkt_cnt returns to 0. The next packet starts fresh.
- Push (ap_hs side): in_hs_ap_ack = !full && !in_reset. It is a function of registered state only, with no combinational path from outStream_tready or in_hs_ap_vld. A transfer occurs on a cycle with in_hs_ap_vld && in_hs_ap_ack, and in_hs is written at wr_ptr.
- Pop (stream side): outStream_tvalid = !empty. outStream_tdata = mem[rd_ptr]. A transfer occurs when tvalid && tready.
- AXI rule: once tvalid=1, tdata, tlast and tvalid hold stable until tready. This holds by construction, because the head only moves on a pop.
- Latency: a word accepted in cycle N is visible on outStream_tvalid in cycle N+1 when the FIFO was empty. Sustained throughput is 1 word/cycle when DEPTH >= 2 and tready=1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits. full = (count == DEPTH), empty = (count == 0).
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Push when full: not possible, because ack=0. A pop in the same cycle frees space only from the next cycle on.
- Pop when empty: not possible, because tvalid=0. A push into an empty FIFO is not bypassed to the output in the same cycle.
- TLAST: pkt_cnt is 16 bits. outStream_tlast = tvalid && (pkt_cnt == PKT_WORDS-1). On each pop, pkt_cnt increments, or wraps to 0 if it was PKT_WORDS-1. PKT_WORDS=1 gives tlast=1 on every valid word.
- occupancy = count, registered.
- Elaboration errors: DEPTH not a power of two, DEPTH < 2, or PKT_WORDS outside 1..65535.

Decomposition:
- Shared package (hs_stream_pkg):
  - STREAM_DATA_W=64
  - PKT_CNT_W=16
  - a function computing pointer width from depth, shared with the stream-to-handshake adapter.
- One natural sub-module: sync_fifo_fwft, a first-word-fall-through FIFO with push/pop/full/empty/count.
- The top level holds the reset synchroniser, the handshake mapping and the TLAST counter.

Test Plan:
- Reset behaviour: hold aresetn=0 with in_hs_ap_vld=1 -> ack=0, tvalid=0, occupancy=0. Release -> ack=1 within 3 cycles and no spurious word emitted.
- Streaming: DEPTH=2, PKT_WORDS=4, tready=1, push 0x10..0x17 back-to-back -> 8 words in order at 1/cycle. First output one cycle after its push. tlast on 0x13 and 0x17 only.
- Backpressure: tready=0, push 0xA,0xB -> ack drops after the 2nd push, occupancy=2, tdata holds 0xA. Raise tready for 1 cycle -> 0xA popped, ack=1 next cycle, occupancy=1.
- Simultaneous push and pop: with full=0, count=1, assert vld and tready together -> occupancy stays 1 and data order is preserved.
- Pointer wrap: DEPTH=4, random vld/tready for 1000 words -> output sequence equals input sequence. tlast asserted every PKT_WORDS words, with none missed and none extra.
- Mid-operation reset: assert aresetn low after 3 of 4 packet words -> tvalid=0 immediately. After release, the next 4 words give tlast on the 4th word, with pkt_cnt restarted at 0.
